cla_addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. Operands are split into BLOCK-bit lookahead groups, and the carry chain is cut into PIPE register segments, so throughput stays one operation per cycle at any WIDTH. Its flags make it the ALU add/sub path: carry/not-borrow, signed overflow and zero.

---
 rtl/cla_addsub_pipe.sv | 153 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: block carry-lookahead adder/subtractor whose carry chain
// is cut into PIPE registered segments, with valid/ready on both sides.
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int PIPE  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG  = WIDTH / PIPE;
    localparam int NGRP = SEG / BLOCK;

    typedef struct packed {
        logic           cmsb;
        logic           co;
        logic [SEG-1:0] s;
    } seg_t;

    // Group G/P per BLOCK bits, group carries, then bit carries inside a group.
    function automatic seg_t seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  c;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        seg_t            o;
        g  = x & y;
        p  = x ^ y;
        c  = '0;
        gg = '0;
        gp = '1;
        gc = '0;
        gc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLOCK+i];
            end
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c[j*BLOCK] = gc[j];
            for (int i = 1; i < BLOCK; i++) begin
                c[j*BLOCK+i] = g[j*BLOCK+i-1]
                             | (p[j*BLOCK+i-1] & c[j*BLOCK+i-1]);
            end
        end
        o.s    = p ^ c;
        o.co   = gc[NGRP];
        o.cmsb = c[SEG-1];
        return o;
    endfunction

    logic             stage_valid [PIPE];
    logic             stage_carry [PIPE];
    logic [WIDTH-1:0] stage_sum   [PIPE];
    logic [WIDTH-1:0] stage_a     [PIPE];
    logic [WIDTH-1:0] stage_b     [PIPE];
    logic             stage_ovf;

    logic             nxt_valid [PIPE];
    logic             nxt_carry [PIPE];
    logic             nxt_cmsb  [PIPE];
    logic [WIDTH-1:0] nxt_sum   [PIPE];
    logic [WIDTH-1:0] nxt_a     [PIPE];
    logic [WIDTH-1:0] nxt_b     [PIPE];

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operands shift right by SEG each stage; results enter at the top.
    for (genvar k = 0; k < PIPE; k++) begin : g_seg
        logic [WIDTH-1:0] ax;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] sx;
        logic             cx;
        logic             vx;
        seg_t             sg;

        if (k == 0) begin : g_head
            assign ax = a;
            assign bx = b ^ {WIDTH{sub}};
            assign sx = '0;
            assign cx = sub | cin;
            assign vx = in_valid;
        end else begin : g_body
            assign ax = stage_a[k-1];
            assign bx = stage_b[k-1];
            assign sx = stage_sum[k-1];
            assign cx = stage_carry[k-1];
            assign vx = stage_valid[k-1];
        end

        assign sg           = seg_add(ax[SEG-1:0], bx[SEG-1:0], cx);
        assign nxt_valid[k] = vx;
        assign nxt_carry[k] = sg.co;
        assign nxt_cmsb[k]  = sg.cmsb;
        assign nxt_a[k]     = ax >> SEG;
        assign nxt_b[k]     = bx >> SEG;
        assign nxt_sum[k]   = (sx >> SEG)
                            | (WIDTH'(sg.s) << (WIDTH - SEG));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE; k++) begin
                stage_valid[k] <= 1'b0;
                stage_carry[k] <= 1'b0;
                stage_sum[k]   <= '0;
                stage_a[k]     <= '0;
                stage_b[k]     <= '0;
            end
            stage_ovf <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < PIPE; k++) begin
                stage_valid[k] <= nxt_valid[k];
                stage_carry[k] <= nxt_carry[k];
                stage_sum[k]   <= nxt_sum[k];
                stage_a[k]     <= nxt_a[k];
                stage_b[k]     <= nxt_b[k];
            end
            stage_ovf <= nxt_carry[PIPE-1] ^ nxt_cmsb[PIPE-1];
        end
    end

    assign out_valid = stage_valid[PIPE-1];
    assign result    = stage_sum[PIPE-1];
    assign cout      = stage_carry[PIPE-1];
    assign overflow  = stage_ovf;
    assign zero      = ~|result;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed vectors, random stream against an arithmetic
// model, backpressure, mid-flight reset and alternate-parameter instances.
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, cin;
    logic        out_valid, out_ready, cout, overflow, zero;
    logic [31:0] a, b, result;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .PIPE(2)) dut (
        .clock(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .overflow(overflow), .zero(zero)
    );

    logic        vv, vsub, vcin, vrdy;
    logic [31:0] va, vb;
    logic [15:0] va16, vb16;
    logic        p1_irdy, p1_valid, p1_c, p1_o, p1_z;
    logic        p4_irdy, p4_valid, p4_c, p4_o, p4_z;
    logic        w16_irdy, w16_valid, w16_c, w16_o, w16_z;
    logic [31:0] p1_res, p4_res;
    logic [15:0] w16_res;

    cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .PIPE(1)) u_p1 (
        .clock(clk), .reset(rst), .in_valid(vv), .in_ready(p1_irdy),
        .a(va), .b(vb), .sub(vsub), .cin(vcin),
        .out_valid(p1_valid), .out_ready(vrdy), .result(p1_res),
        .cout(p1_c), .overflow(p1_o), .zero(p1_z)
    );

    cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .PIPE(4)) u_p4 (
        .clock(clk), .reset(rst), .in_valid(vv), .in_ready(p4_irdy),
        .a(va), .b(vb), .sub(vsub), .cin(vcin),
        .out_valid(p4_valid), .out_ready(vrdy), .result(p4_res),
        .cout(p4_c), .overflow(p4_o), .zero(p4_z)
    );

    cla_addsub_pipe #(.WIDTH(16), .BLOCK(2), .PIPE(2)) u_w16 (
        .clock(clk), .reset(rst), .in_valid(vv), .in_ready(w16_irdy),
        .a(va16), .b(vb16), .sub(vsub), .cin(vcin),
        .out_valid(w16_valid), .out_ready(vrdy), .result(w16_res),
        .cout(w16_c), .overflow(w16_o), .zero(w16_z)
    );

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        ci;
        res_t        e;
    } vec_t;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Reference arithmetic: 64-bit unsigned and signed sums.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input logic ci);
        longint unsigned ux, uy, us;
        longint          sx, sy, ss;
        longint          smax, smin;
        res_t            r;
        smax = 2147483647;
        smin = -smax - 1;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            us  = ux - uy;
            ss  = sx - sy;
            r.c = (ux >= uy);
        end else begin
            us  = ux + uy + {63'd0, ci};
            ss  = sx + sy + longint'({63'd0, ci});
            r.c = (us >= 64'h1_0000_0000);
        end
        r.r = us[31:0];
        r.v = (ss > smax) || (ss < smin);
        r.z = (r.r == 32'd0);
        return r;
    endfunction

    task automatic check_res(input string nm, input res_t e);
        chk({nm, "_result"}, result, e.r);
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, e.c});
        chk({nm, "_overflow"}, {31'd0, overflow}, {31'd0, e.v});
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, e.z});
    endtask

    // One cycle: drive at negedge, then score what the next edge will do.
    task automatic step(input logic v, input logic [31:0] x,
                        input logic [31:0] y, input logic s,
                        input logic ci, input logic ordy);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        sub       = s;
        cin       = ci;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_pop++;
                check_res("sb", e);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(x, y, s, ci));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy);
    endtask

    task automatic run_vec(input string nm, input vec_t t);
        step(1'b1, t.a, t.b, t.s, t.ci, 1'b1);
        idle(1'b1);
        chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_res(nm, t.e);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        vec_t        bp[4];
        int          idx;
        int          n0;
        logic [31:0] hr;
        logic        hc, ho, hz;
        logic        ordy;

        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0,
                   '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0,
                   '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
                   '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1,
                   '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1,
                   '{32'h2345_678A, 1'b0, 1'b0, 1'b0}};
        tbl[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1,
                   '{32'h0000_0007, 1'b1, 1'b0, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        cin = 1'b0; out_ready = 1'b1;
        vv = 1'b0; va = '0; vb = '0; va16 = '0; vb16 = '0;
        vsub = 1'b0; vcin = 1'b0; vrdy = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        n0 = n_pop;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
            if (i >= 2) chk("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        repeat (3) idle(1'b1);
        chk("stream_count", n_pop - n0, 32'd100);
        chk("stream_drained", exp_q.size(), 32'd0);

        for (int i = 0; i < 4; i++)
            bp[i] = '{$urandom, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), '{32'd0, 1'b0, 1'b0, 1'b0}};
        idx = 0;
        n0  = n_pop;
        hr  = '0; hc = 1'b0; ho = 1'b0; hz = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            ordy = !(cyc >= 3 && cyc <= 5);
            if (idx < 4) step(1'b1, bp[idx].a, bp[idx].b, bp[idx].s,
                              bp[idx].ci, ordy);
            else idle(ordy);
            if (cyc == 3) begin
                chk("bp_valid", {31'd0, out_valid}, 32'd1);
                hr = result; hc = cout; ho = overflow; hz = zero;
            end
            if (cyc >= 3 && cyc <= 5)
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (cyc >= 4 && cyc <= 6) begin
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_result", result, hr);
                chk("bp_hold_flags", {29'd0, cout, overflow, zero},
                    {29'd0, hc, ho, hz});
            end
            if (in_valid && in_ready) idx++;
        end
        chk("bp_count", n_pop - n0, 32'd4);
        chk("bp_empty", exp_q.size(), 32'd0);

        step(1'b1, 32'd11, 32'd22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd33, 32'd44, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        chk("rst_mid_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_async", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        run_vec("post_rst", tbl[4]);

        @(negedge clk);
        vv = 1'b1; va = 32'hFFFF_FFFF; vb = 32'h1;
        va16 = 16'hFFFF; vb16 = 16'h1;
        #1;
        chk("var_in_ready", {29'd0, p1_irdy, p4_irdy, w16_irdy}, 32'd7);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            vv = 1'b0;
            #1;
            chk("p1_valid", {31'd0, p1_valid}, {31'd0, e == 1});
            chk("p4_valid", {31'd0, p4_valid}, {31'd0, e == 4});
            chk("w16_valid", {31'd0, w16_valid}, {31'd0, e == 2});
            if (e == 1) begin
                chk("p1_result", p1_res, 32'd0);
                chk("p1_flags", {29'd0, p1_c, p1_o, p1_z}, 32'b101);
            end
            if (e == 4) begin
                chk("p4_result", p4_res, 32'd0);
                chk("p4_flags", {29'd0, p4_c, p4_o, p4_z}, 32'b101);
            end
            if (e == 2) begin
                chk("w16_result", {16'd0, w16_res}, 32'd0);
                chk("w16_flags", {29'd0, w16_c, w16_o, w16_z}, 32'b101);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
